fetch_unit: RTL and testbench

- Parametrised next-generation instruction fetch stage.
- Issues aligned fetch-block requests to the icache over a valid/ready request channel and accepts in-order responses.
- Tags every in-flight request with an epoch so that responses made stale by a redirect are discarded.
- Buffers responses internally and presents lane-masked instruction bundles to the instruction buffer with valid/ready back-pressure.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_sync_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/micro-op header: fetch-block entry, in-flight request tag, helpers.
package fetch_unit_pkg;

    // Default instructions per fetch block (power of two, 1..8)
    localparam int FETCH_WIDTH_DEFAULT = 2;

    // Tag field widths are sized for the largest supported configuration;
    // the fetch unit zero-extends its live epoch/lane values into them.
    localparam int TAG_EPOCH_W = 8;
    localparam int TAG_LANE_W  = 3;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fb_entry_t;

    typedef struct packed {
        logic [TAG_EPOCH_W-1:0] epoch;
        logic [TAG_LANE_W-1:0]  start_lane;
    } fetch_tag_t;

    // Clear the byte/lane offset bits of a PC for a block of fw instructions
    function automatic logic [31:0] block_base(input logic [31:0] pc, input int fw);
        return pc & ~((32'(fw) << 2) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with count/full, optional flush and optional empty bypass.
// With BYPASS set, data pushed into an empty FIFO is visible at the head in
// the same cycle, and a simultaneous pop consumes it without storing it.
module fetch_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_pass;
    logic             w_wr;
    logic             w_rd;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign w_pass  = BYPASS && w_empty && i_push && i_pop;
    assign w_wr    = i_push && !w_pass && (!o_full || i_pop);
    assign w_rd    = i_pop && !w_empty;
    assign o_valid = !w_empty || (BYPASS && i_push);
    assign o_head  = (BYPASS && w_empty) ? i_data : r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; flush empties the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
        end
    end

    // Storage array, no reset needed since entries are qualified by count
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues block-aligned icache requests under a credit
// limit, tags them with an epoch, drops responses made stale by redirects and
// presents lane-masked bundles to the instruction buffer.
// Handshake rule for every channel here: a transfer happens on a rising edge
// where valid and ready are both high; valid never waits on ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FETCH_WIDTH     = FETCH_WIDTH_DEFAULT,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    localparam int         EPOCH_W         = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        branch_taken,
    input  logic [31:0]                 branch_pc,
    input  logic                        bp_taken,
    input  logic [31:0]                 bp_target,
    output logic                        core2icache_req_valid,
    input  logic                        core2icache_req_ready,
    output logic [31:0]                 core2icache_addr,
    input  logic                        icache2core_resp_valid,
    input  logic [32*FETCH_WIDTH-1:0]   icache2core_data,
    output fb_entry_t [FETCH_WIDTH-1:0] insts_out,
    output logic [FETCH_WIDTH-1:0]      insts_out_lane_valid,
    output logic                        insts_out_valid,
    input  logic                        insts_out_ready
);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TAG_W  = $bits(fetch_tag_t) + 32;
    localparam int RESP_W = 32 * FETCH_WIDTH + 32 + TAG_LANE_W;

    logic [31:0]         r_pc;
    logic [EPOCH_W-1:0]  r_epoch;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_active;

    logic [31:0]         w_block_base;
    fetch_tag_t          w_tag_new;
    logic [TAG_W-1:0]    w_tag_head;
    fetch_tag_t          w_tag_s;
    logic [31:0]         w_tag_base;
    logic                w_tag_valid;
    logic                w_tag_full;
    logic [CNT_W-1:0]    w_tag_count;
    logic                w_can_issue;
    logic                w_fire;
    logic                w_resp_take;
    logic                w_resp_push;
    logic [RESP_W-1:0]   w_resp_head;
    logic                w_resp_valid;
    logic                w_resp_full;
    logic [CNT_W-1:0]    w_resp_count;
    logic                w_out_pop;
    logic [31:0]         w_h_base;
    logic [TAG_LANE_W-1:0] w_h_lane;

    assign w_block_base         = block_base(r_pc, FETCH_WIDTH);
    assign core2icache_addr     = w_block_base;
    assign w_tag_new.epoch      = TAG_EPOCH_W'(r_epoch);
    assign w_tag_new.start_lane = TAG_LANE_W'((r_pc >> 2) & 32'(FETCH_WIDTH - 1));

    // Credit counts both in-flight requests and buffered responses
    assign w_can_issue = (32'(r_outstanding) + 32'(w_resp_count)) < 32'(MAX_OUTSTANDING);
    assign core2icache_req_valid = r_active && w_can_issue && !branch_taken;
    assign w_fire = core2icache_req_valid && core2icache_req_ready;

    assign w_tag_s     = w_tag_head[$bits(fetch_tag_t)-1:0];
    assign w_tag_base  = w_tag_head[TAG_W-1 -: 32];
    assign w_resp_take = icache2core_resp_valid && w_tag_valid;
    assign w_resp_push = w_resp_take && !branch_taken &&
                         (w_tag_s.epoch == TAG_EPOCH_W'(r_epoch));
    assign w_out_pop   = w_resp_valid && insts_out_ready && !branch_taken;
    assign insts_out_valid = w_resp_valid;

    fetch_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING), .BYPASS(1'b0)) u_tag_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (w_fire),
        .i_pop   (w_resp_take),
        .i_flush (1'b0),
        .i_data  ({w_block_base, w_tag_new}),
        .o_head  (w_tag_head),
        .o_valid (w_tag_valid),
        .o_full  (w_tag_full),
        .o_count (w_tag_count)
    );

    fetch_sync_fifo #(.WIDTH(RESP_W), .DEPTH(MAX_OUTSTANDING), .BYPASS(1'b1)) u_resp_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (w_resp_push),
        .i_pop   (w_out_pop),
        .i_flush (branch_taken),
        .i_data  ({icache2core_data, w_tag_base, w_tag_s.start_lane}),
        .o_head  (w_resp_head),
        .o_valid (w_resp_valid),
        .o_full  (w_resp_full),
        .o_count (w_resp_count)
    );

    assign w_h_base = w_resp_head[TAG_LANE_W +: 32];
    assign w_h_lane = w_resp_head[TAG_LANE_W-1:0];

    // Unpack the FIFO head into per-lane entries; all zero when nothing is valid
    always_comb begin
        insts_out            = '0;
        insts_out_lane_valid = '0;
        if (w_resp_valid) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                insts_out[i].inst       = w_resp_head[32*FETCH_WIDTH + 32 + TAG_LANE_W - 32*(FETCH_WIDTH-i) +: 32];
                insts_out[i].pc         = w_h_base + 32'(4 * i);
                insts_out_lane_valid[i] = (TAG_LANE_W'(i) >= w_h_lane);
            end
        end
    end

    // PC, epoch, in-flight count; redirect wins over fire and responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_epoch       <= '0;
            r_outstanding <= '0;
            r_active      <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (branch_taken) begin
                r_pc    <= branch_pc;
                r_epoch <= r_epoch + 1'b1;
            end else if (w_fire) begin
                r_pc <= bp_taken ? bp_target : w_block_base + 32'(4 * FETCH_WIDTH);
            end
            if (w_fire && !w_resp_take)      r_outstanding <= r_outstanding + 1'b1;
            else if (w_resp_take && !w_fire) r_outstanding <= r_outstanding - 1'b1;
        end
    end

    // Protocol and bookkeeping checks
    a_resp_without_req: assert property (@(posedge clock) disable iff (!reset_n)
        icache2core_resp_valid |-> (r_outstanding != '0));
    a_addr_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (core2icache_req_valid && !core2icache_req_ready && !branch_taken) |=> $stable(core2icache_addr));
    a_tag_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        w_fire |-> (!w_tag_full || w_resp_take));
    a_tag_tracks_count: assert property (@(posedge clock) disable iff (!reset_n)
        w_tag_count == r_outstanding);
    a_resp_no_overrun: assert property (@(posedge clock) disable iff (!reset_n)
        w_resp_push |-> (!w_resp_full || w_out_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle icache model and a bundle scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int FW = 2;
    localparam int MO = 2;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   branch_taken = 1'b0;
    logic [31:0]            branch_pc = '0;
    logic                   bp_taken = 1'b0;
    logic [31:0]            bp_target = '0;
    logic                   core2icache_req_valid;
    logic                   core2icache_req_ready = 1'b0;
    logic [31:0]            core2icache_addr;
    logic                   icache2core_resp_valid = 1'b0;
    logic [32*FW-1:0]       icache2core_data = '0;
    fb_entry_t [FW-1:0]     insts_out;
    logic [FW-1:0]          insts_out_lane_valid;
    logic                   insts_out_valid;
    logic                   insts_out_ready = 1'b0;

    // clock / reset
    always #5 clock = ~clock;

    fetch_unit #(.FETCH_WIDTH(FW), .MAX_OUTSTANDING(MO), .RESET_PC(32'h0)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .branch_taken           (branch_taken),
        .branch_pc              (branch_pc),
        .bp_taken               (bp_taken),
        .bp_target              (bp_target),
        .core2icache_req_valid  (core2icache_req_valid),
        .core2icache_req_ready  (core2icache_req_ready),
        .core2icache_addr       (core2icache_addr),
        .icache2core_resp_valid (icache2core_resp_valid),
        .icache2core_data       (icache2core_data),
        .insts_out              (insts_out),
        .insts_out_lane_valid   (insts_out_lane_valid),
        .insts_out_valid        (insts_out_valid),
        .insts_out_ready        (insts_out_ready)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_deliv = 0;
    int          cyc_n = 0;
    logic [33:0] exp_q[$];      // {lane mask, block base}
    logic [31:0] ic_q[$];       // icache requests awaiting response
    logic [31:0] req_log[$];
    int          fire_cyc[$];
    int          deliv_cyc[$];
    logic        want_req_ready = 1'b0;
    logic        want_ready = 1'b1;
    logic        ic_en = 1'b1;
    logic        bp_en = 1'b0;
    logic [31:0] bp_at = '0;
    logic [31:0] bp_to = '0;
    logic        obs_req_valid;
    logic        obs_out_valid;
    logic [31:0] obs_addr;
    logic [31:0] obs_head_pc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    // driver: one clock cycle, inputs applied at negedge, outputs sampled 1ns later
    task automatic cyc(input logic br, input logic [31:0] bpc);
        logic [33:0] e;
        logic [31:0] a;
        @(negedge clock);
        branch_taken           = br;
        branch_pc              = bpc;
        core2icache_req_ready  = want_req_ready;
        insts_out_ready        = want_ready;
        icache2core_resp_valid = 1'b0;
        icache2core_data       = '0;
        if (ic_en && ic_q.size() > 0) begin
            a = ic_q.pop_front();
            icache2core_resp_valid = 1'b1;
            for (int i = 0; i < FW; i++) icache2core_data[32*i +: 32] = inst_of(a + 32'(4 * i));
        end
        bp_taken  = bp_en && (core2icache_addr == bp_at);
        bp_target = bp_to;
        #1;
        obs_req_valid = core2icache_req_valid;
        obs_out_valid = insts_out_valid;
        obs_addr      = core2icache_addr;
        obs_head_pc   = insts_out[0].pc;
        if (insts_out_valid && insts_out_ready && !branch_taken) begin
            n_deliv++;
            deliv_cyc.push_back(cyc_n);
            check_eq("bundle_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("lane_mask", 64'(insts_out_lane_valid), 64'(e[33:32]));
                for (int i = 0; i < FW; i++) begin
                    check_eq("lane_pc", 64'(insts_out[i].pc), 64'(e[31:0] + 32'(4 * i)));
                    check_eq("lane_inst", 64'(insts_out[i].inst), 64'(inst_of(e[31:0] + 32'(4 * i))));
                end
            end
        end
        if (core2icache_req_valid && core2icache_req_ready) begin
            req_log.push_back(core2icache_addr);
            ic_q.push_back(core2icache_addr);
            fire_cyc.push_back(cyc_n);
        end
        cyc_n++;
        @(posedge clock);
    endtask

    task automatic issue_n(input int n);
        int target;
        int guard;
        target = req_log.size() + n;
        guard = 0;
        want_req_ready = 1'b1;
        while (req_log.size() < target && guard < 40) begin
            cyc(1'b0, 32'h0);
            guard++;
        end
        want_req_ready = 1'b0;
        check_eq("issue_timeout", 64'(guard < 40), 64'd1);
    endtask

    task automatic drain(input int k);
        repeat (k) cyc(1'b0, 32'h0);
    endtask

    initial begin
        int d0;
        int l0;
        logic stable_bad;

        // reset state
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_req_valid", 64'(core2icache_req_valid), 64'd0);
        check_eq("rst_out_valid", 64'(insts_out_valid), 64'd0);
        check_eq("rst_lane_valid", 64'(insts_out_lane_valid), 64'd0);
        check_eq("rst_insts_zero", 64'(insts_out != '0), 64'd0);
        check_eq("rst_addr", 64'(core2icache_addr), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // sequential stream, one block per cycle
        exp_q.push_back({2'b11, 32'h0});
        exp_q.push_back({2'b11, 32'h8});
        exp_q.push_back({2'b11, 32'h10});
        issue_n(3);
        drain(4);
        check_eq("t1_addr0", 64'(req_log[0]), 64'h0);
        check_eq("t1_addr1", 64'(req_log[1]), 64'h8);
        check_eq("t1_addr2", 64'(req_log[2]), 64'h10);
        check_eq("t1_fire_gap1", 64'(fire_cyc[1] - fire_cyc[0]), 64'd1);
        check_eq("t1_fire_gap2", 64'(fire_cyc[2] - fire_cyc[1]), 64'd1);
        check_eq("t1_deliv_count", 64'(deliv_cyc.size()), 64'd3);
        if (deliv_cyc.size() == 3) begin
            check_eq("t1_latency", 64'(deliv_cyc[0] - fire_cyc[0]), 64'd1);
            check_eq("t1_deliv_gap1", 64'(deliv_cyc[1] - deliv_cyc[0]), 64'd1);
            check_eq("t1_deliv_gap2", 64'(deliv_cyc[2] - deliv_cyc[1]), 64'd1);
        end
        check_eq("t1_drained", 64'(exp_q.size()), 64'd0);
        check_eq("t1_hold_valid", 64'(obs_req_valid), 64'd1);
        check_eq("t1_hold_addr", 64'(obs_addr), 64'h18);

        // redirect into the middle of a block
        cyc(1'b1, 32'h104);
        exp_q.push_back({2'b10, 32'h100});
        issue_n(1);
        drain(3);
        check_eq("t2_addr", 64'(req_log[req_log.size()-1]), 64'h100);
        check_eq("t2_drained", 64'(exp_q.size()), 64'd0);

        // two requests in flight, then redirect: both responses dropped
        cyc(1'b1, 32'h0);
        ic_en = 1'b0;
        issue_n(2);
        cyc(1'b0, 32'h0);
        check_eq("t3_credit_full", 64'(obs_req_valid), 64'd0);
        check_eq("t3_inflight0", 64'(req_log[req_log.size()-2]), 64'h0);
        check_eq("t3_inflight1", 64'(req_log[req_log.size()-1]), 64'h8);
        cyc(1'b1, 32'h200);
        ic_en = 1'b1;
        d0 = n_deliv;
        exp_q.push_back({2'b11, 32'h200});
        issue_n(1);
        drain(3);
        check_eq("t3_addr", 64'(req_log[req_log.size()-1]), 64'h200);
        check_eq("t3_deliv_count", 64'(n_deliv - d0), 64'd1);
        check_eq("t3_drained", 64'(exp_q.size()), 64'd0);

        // back-pressure: ready low for 10 cycles
        want_ready = 1'b0;
        want_req_ready = 1'b1;
        l0 = req_log.size();
        d0 = n_deliv;
        stable_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 32'h0);
            if (obs_out_valid && obs_head_pc != 32'h208) stable_bad = 1'b1;
        end
        want_req_ready = 1'b0;
        check_eq("t4_req_count", 64'(req_log.size() - l0), 64'd2);
        check_eq("t4_req_stopped", 64'(obs_req_valid), 64'd0);
        check_eq("t4_out_valid", 64'(obs_out_valid), 64'd1);
        check_eq("t4_head_pc", 64'(obs_head_pc), 64'h208);
        check_eq("t4_head_stable", 64'(stable_bad), 64'd0);
        check_eq("t4_no_deliv", 64'(n_deliv - d0), 64'd0);
        exp_q.push_back({2'b11, 32'h208});
        exp_q.push_back({2'b11, 32'h210});
        want_ready = 1'b1;
        drain(4);
        check_eq("t4_deliv_count", 64'(n_deliv - d0), 64'd2);
        check_eq("t4_drained", 64'(exp_q.size()), 64'd0);

        // predicted-taken block
        cyc(1'b1, 32'h0);
        bp_en = 1'b1;
        bp_at = 32'h8;
        bp_to = 32'h40;
        exp_q.push_back({2'b11, 32'h0});
        exp_q.push_back({2'b11, 32'h8});
        exp_q.push_back({2'b11, 32'h40});
        issue_n(3);
        bp_en = 1'b0;
        drain(3);
        check_eq("t5_addr1", 64'(req_log[req_log.size()-2]), 64'h8);
        check_eq("t5_addr2", 64'(req_log[req_log.size()-1]), 64'h40);
        check_eq("t5_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset with a buffered bundle and a pending response
        cyc(1'b1, 32'h300);
        want_ready = 1'b0;
        issue_n(2);
        ic_en = 1'b0;
        cyc(1'b0, 32'h0);
        check_eq("t6_pre_out_valid", 64'(obs_out_valid), 64'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_req_valid", 64'(core2icache_req_valid), 64'd0);
        check_eq("t6_rst_out_valid", 64'(insts_out_valid), 64'd0);
        check_eq("t6_rst_lane_valid", 64'(insts_out_lane_valid), 64'd0);
        ic_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        want_ready = 1'b1;
        ic_en = 1'b1;
        d0 = n_deliv;
        exp_q.push_back({2'b11, 32'h0});
        issue_n(1);
        drain(3);
        check_eq("t6_first_addr", 64'(req_log[req_log.size()-1]), 64'h0);
        check_eq("t6_deliv_count", 64'(n_deliv - d0), 64'd1);
        check_eq("t6_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
